md_sched: RTL

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched -- multi-cycle HI/LO unit for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//
// An accepted multiply or divide latches its operands and holds busy high
// for a fixed number of cycles. The result is written to HI/LO on the edge
// that ends the busy period. MTHI/MTLO write HI or LO in a single cycle and
// never assert busy.
//
// Parameters:
//   MULT_CYCLES  busy length of MULT/MULTU (0 treated as 1)
//   DIV_CYCLES   busy length of DIV/DIVU   (0 treated as 1)
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous active-high reset
//   start  in   1   issue strobe from the E stage
//   op     in   3   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//   A      in   32  rs operand (multiplicand / dividend / MTHI-MTLO data)
//   B      in   32  rt operand (multiplier / divisor)
//   req    in   1   CP0 flush; blocks an issue in the same cycle
//   busy   out  1   operation in flight
//   hi     out  32  HI register
//   lo     out  32  LO register
// ---------------------------------------------------------------------------
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  // A zero-length setting would leave no cycle in which to commit, so it is
  // stretched to one cycle.
  localparam logic [31:0] MUL_LEN = (MULT_CYCLES == 0) ? 32'd1 : 32'(MULT_CYCLES);
  localparam logic [31:0] DIV_LEN = (DIV_CYCLES == 0) ? 32'd1 : 32'(DIV_CYCLES);

  state_t      state, state_d;
  logic [31:0] count, count_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        signed_q, signed_d;
  logic [31:0] hi_d, lo_d;

  logic [63:0] product;
  logic [31:0] a_mag, b_mag, den, q_mag, r_mag, quot, rem;

  // Sign-extending both operands to 64 bits makes the low 64 bits of an
  // unsigned product equal to the signed product, so one multiplier serves
  // both MULT and MULTU.
  always_comb begin
    product = {{32{signed_q & a_q[31]}}, a_q} * {{32{signed_q & b_q[31]}}, b_q};
  end

  // Signed division runs on magnitudes and re-applies signs afterwards:
  // quotient is negative when operand signs differ, remainder follows the
  // dividend. 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  // The divisor is forced to 1 when zero; that result is never committed.
  always_comb begin
    a_mag = (signed_q && a_q[31]) ? -a_q : a_q;
    b_mag = (signed_q && b_q[31]) ? -b_q : b_q;
    den   = (b_q == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / den;
    r_mag = a_mag % den;
    quot  = (signed_q && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    rem   = (signed_q && a_q[31]) ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      signed_q <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      hi       <= hi_d;
      lo       <= lo_d;
    end
  end

  // Issue is only possible from IDLE, so a start arriving on the edge that
  // ends a busy period is dropped. The counter holds the number of busy
  // cycles still to run, including the current one; the commit happens when
  // it reads 1.
  always_comb begin
    state_d  = state;
    count_d  = count;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    hi_d     = hi;
    lo_d     = lo;
    case (state)
      IDLE: begin
        if (start && !req) begin
          case (op)
            3'd1, 3'd2: begin
              a_d      = A;
              b_d      = B;
              signed_d = (op == 3'd1);
              count_d  = MUL_LEN;
              state_d  = MUL;
            end
            3'd3, 3'd4: begin
              a_d      = A;
              b_d      = B;
              signed_d = (op == 3'd3);
              count_d  = DIV_LEN;
              state_d  = DIV;
            end
            3'd5: hi_d = A;
            3'd6: lo_d = A;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (count <= 32'd1) begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          count_d = 32'd0;
          state_d = IDLE;
        end else begin
          count_d = count - 32'd1;
        end
      end
      DIV: begin
        if (count <= 32'd1) begin
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
          count_d = 32'd0;
          state_d = IDLE;
        end else begin
          count_d = count - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
